iref_ctrl: RTL
==============

IREF_CTRL -- requirements
Module: iref_ctrl

Interface
REQ-001 Parameter T_SETTLE, default 5, PU_IREF-high settle cycles before calibration (1 us at 5 MHz).
REQ-002 Parameter T_TIMEOUT, default 50, maximum CAL_IREF-high cycles awaiting RDY_IREF.
REQ-003 Parameter T_OFF, default 5, PU_IREF-low cycles between retry attempts.
REQ-004 Parameter MAX_RETRY, default 2, retries after the first attempt before fault.
REQ-005 CLK  input  1  single clock, rising-edge active, 5 MHz nominal.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 EN  input  1  level request: high = bring reference up, low = power down and abort.
REQ-008 RDY_IREF  input  1  ready from the current reference, synchronous to CLK.
REQ-009 PU_IREF  output  1  power-up to the current reference.
REQ-010 CAL_IREF  output  1  calibration enable to the current reference.
REQ-011 DONE  output  1  reference powered, calibrated, ready.
REQ-012 ERR  output  1  calibration failed after all retries, or ready lost.
REQ-013 STATE  output  3  current FSM state code.
REQ-014 RETRY_CNT  output  2  retries consumed in the current request.

Function
REQ-015 The FSM SHALL have states IDLE=0, SETTLE=1, CAL=2, OFF=3, READY=4, FAULT=5; codes 6-7 SHALL go to IDLE.
REQ-016 All outputs SHALL be Moore outputs decoded from the state register only: PU_IREF=1 in SETTLE/CAL/READY; CAL_IREF=1 in CAL only; DONE=1 in READY only; ERR=1 in FAULT only.
REQ-017 IDLE: EN sampled high SHALL move to SETTLE next cycle, loading the 16-bit timer with T_SETTLE and clearing RETRY_CNT.
REQ-018 SETTLE SHALL last exactly T_SETTLE cycles, then go to CAL loading the timer with T_TIMEOUT; T_SETTLE=0 SHALL behave as 1.
REQ-019 RDY_IREF SHALL be ignored in every state except CAL and READY.
REQ-020 CAL: RDY_IREF sampled high SHALL move to READY next cycle; DONE is therefore high 1 cycle after the first high RDY_IREF sample.
REQ-021 CAL: after T_TIMEOUT cycles without RDY_IREF, if RETRY_CNT < MAX_RETRY the FSM SHALL go to OFF, increment RETRY_CNT, and load the timer with T_OFF; otherwise it SHALL go to FAULT.
REQ-022 If RDY_IREF is high on the same cycle the timeout expires, ready SHALL win (go to READY).
REQ-023 OFF SHALL last T_OFF cycles with PU_IREF=0, then go to SETTLE loading T_SETTLE.
REQ-024 READY: RDY_IREF sampled low while EN high SHALL move to FAULT (loss of reference).
REQ-025 EN sampled low in any state SHALL move to IDLE next cycle; abort has priority over every other transition.
REQ-026 FAULT SHALL hold with PU_IREF=0 until EN is sampled low; re-raising EN afterwards starts a fresh request with RETRY_CNT=0.
REQ-027 RETRY_CNT SHALL saturate at MAX_RETRY and hold its value in FAULT.
REQ-028 The timer SHALL decrement by 1 per cycle only in SETTLE, CAL, and OFF, and SHALL never wrap below 0.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, timer 0, RETRY_CNT 0, and PU_IREF/CAL_IREF/DONE/ERR all 0, independent of CLK.
REQ-030 Reset deassertion SHALL take effect at the next CLK rising edge; EN already high at that edge SHALL start SETTLE on the following cycle.
REQ-031 Reset asserted mid-CAL SHALL drop PU_IREF and CAL_IREF within the same cycle, without waiting for a clock edge.

Verification
REQ-032 Nominal: EN=1 at cycle 0 with the reference model requiring 35 CAL cycles -> PU_IREF=1 from cycle 1; CAL_IREF=1 from cycle 6; DONE=1 one cycle after RDY_IREF rises; CAL_IREF=0 in READY; RETRY_CNT=0.
REQ-033 Dead reference, RDY_IREF tied 0 -> three 50-cycle CAL windows separated by two 5-cycle OFF gaps; then FAULT with ERR=1, PU_IREF=0, RETRY_CNT=2, STATE=5.
REQ-034 EN dropped on CAL cycle 20 -> next cycle STATE=0 with PU_IREF=0 and CAL_IREF=0; EN raised again -> SETTLE with RETRY_CNT=0.
REQ-035 RDY_IREF forced low for 1 cycle while in READY -> FAULT next cycle with DONE=0 and ERR=1; EN low clears to IDLE.
REQ-036 RDY_IREF asserted on the exact timeout cycle -> READY, not OFF; RETRY_CNT unchanged.
REQ-037 RST_N pulsed low mid-SETTLE between clock edges -> all outputs 0 asynchronously; restart from SETTLE after release with EN=1.

Source files
------------

// File: rtl/iref_ctrl_if.sv
`timescale 1ns/1ps
// Request/status bundle between the bias sequencer and its current reference.
// The slave side is the controller; the master side owns en and rdy_iref.
interface iref_ctrl_if;
    logic       en;
    logic       rdy_iref;
    logic       pu_iref;
    logic       cal_iref;
    logic       done;
    logic       err;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport master (
        output en, rdy_iref,
        input  pu_iref, cal_iref, done, err, state, retry_cnt
    );

    modport slave (
        input  en, rdy_iref,
        output pu_iref, cal_iref, done, err, state, retry_cnt
    );
endinterface

// File: rtl/iref_ctrl.sv
`timescale 1ns/1ps
// Current-reference power-up/calibration sequencer with bounded retries and fault latch.
// Moore outputs, one cycle after the sampling edge; en low aborts to idle from any state.
module iref_ctrl #(
    parameter int unsigned T_SETTLE  = 5,
    parameter int unsigned T_TIMEOUT = 50,
    parameter int unsigned T_OFF     = 5,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    iref_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CAL    = 3'd2,
        OFF    = 3'd3,
        READY  = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [15:0] SETTLE_LD  = 16'(T_SETTLE);
    localparam logic [15:0] TIMEOUT_LD = 16'(T_TIMEOUT);
    localparam logic [15:0] OFF_LD     = 16'(T_OFF);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);

    state_t      state_q;
    state_t      state_nxt;
    logic [15:0] timer_q;
    logic [15:0] timer_nxt;
    logic [15:0] timer_dec;
    logic        timer_last;
    logic [1:0]  retry_q;
    logic [1:0]  retry_nxt;

    // A loaded value of 0 or 1 both mean "this is the final cycle", so a zero
    // duration still occupies the state for one cycle.
    assign timer_last = (timer_q <= 16'd1);
    assign timer_dec  = (timer_q == 16'd0) ? 16'd0 : (timer_q - 16'd1);

    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        retry_nxt = retry_q;
        if (!bus.en) begin
            state_nxt = IDLE;
            timer_nxt = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt = SETTLE;
                    timer_nxt = SETTLE_LD;
                    retry_nxt = 2'd0;
                end
                SETTLE: begin
                    if (timer_last) begin
                        state_nxt = CAL;
                        timer_nxt = TIMEOUT_LD;
                    end else begin
                        timer_nxt = timer_dec;
                    end
                end
                CAL: begin
                    // Ready beats a coincident timeout.
                    if (bus.rdy_iref) begin
                        state_nxt = READY;
                    end else if (timer_last) begin
                        if (retry_q < RETRY_MAX) begin
                            state_nxt = OFF;
                            timer_nxt = OFF_LD;
                            retry_nxt = retry_q + 2'd1;
                        end else begin
                            state_nxt = FAULT;
                            timer_nxt = timer_dec;
                        end
                    end else begin
                        timer_nxt = timer_dec;
                    end
                end
                OFF: begin
                    if (timer_last) begin
                        state_nxt = SETTLE;
                        timer_nxt = SETTLE_LD;
                    end else begin
                        timer_nxt = timer_dec;
                    end
                end
                READY: begin
                    if (!bus.rdy_iref) begin
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = 16'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they always match state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= 16'd0;
            retry_q      <= 2'd0;
            bus.pu_iref  <= 1'b0;
            bus.cal_iref <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            timer_q      <= timer_nxt;
            retry_q      <= retry_nxt;
            bus.pu_iref  <= (state_nxt == SETTLE) || (state_nxt == CAL) || (state_nxt == READY);
            bus.cal_iref <= (state_nxt == CAL);
            bus.done     <= (state_nxt == READY);
            bus.err      <= (state_nxt == FAULT);
        end
    end

    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;

endmodule
